mul255_serial: RTL



---
 rtl/mul255_serial_pkg.sv | 13 +
 rtl/mul255_serial_sub8_borrow.sv | 19 +
 rtl/mul255_serial.sv | 118 +++++++++++
 3 files changed

// File: rtl/mul255_serial_pkg.sv
// Shared definitions for the byte-serial multiply-by-255 datapath.
package mul255_serial_pkg;

  // Default operand width in bytes.
  localparam int NBYTES_DEF = 4;

  // Controller states: waiting for a request, or stepping through product bytes.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/mul255_serial_sub8_borrow.sv
// 8-bit subtractor with borrow in/out: {bout, diff} = a - b - bin.
module sub8_borrow (
  input  logic       [7:0] a,
  input  logic       [7:0] b,
  input  logic             bin,
  output logic       [7:0] diff,
  output logic             bout
);

  logic [8:0] wide;

  // A 9-bit difference exposes the borrow as its top bit (set when the result goes negative).
  always_comb begin
    wide = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    diff = wide[7:0];
    bout = wide[8];
  end

endmodule

// File: rtl/mul255_serial.sv
// Byte-serial x*255 = (x<<8) - x, one product byte per clock through a single
// borrow-chained 8-bit subtractor. The full signed product is NBYTES+1 bytes wide.
module mul255_serial
  import mul255_serial_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [8*NBYTES-1:0]       x,
  output logic                      busy,
  output logic                      done,
  output logic [8*(NBYTES+1)-1:0]   out
);

  localparam int XW    = 8 * NBYTES;
  localparam int OW    = 8 * (NBYTES + 1);
  localparam int IDX_W = $clog2(NBYTES + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               borrow_q, borrow_d;
  logic [XW-1:0]      x_q, x_d;
  logic [OW-1:0]      out_q, out_d;
  logic               done_q, done_d;

  logic [OW-1:0]      xe;      // sign-extended operand (subtrahend bytes)
  logic [OW-1:0]      xs;      // operand shifted up one byte (minuend bytes)
  logic [7:0]         a_byte;
  logic [7:0]         b_byte;
  logic [7:0]         diff;
  logic               bout;

  assign xe = {{8{x_q[XW-1]}}, x_q};
  assign xs = {x_q, 8'h00};

  // Select the minuend/subtrahend byte pair for the current byte index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    a_byte = 8'h00;
    b_byte = 8'h00;
    for (int j = 0; j <= NBYTES; j++) begin
      if (idx_q == IDX_W'(j)) begin
        a_byte = xs[8*j +: 8];
        b_byte = xe[8*j +: 8];
      end
    end
  end

  sub8_borrow u_sub (
    .a    (a_byte),
    .b    (b_byte),
    .bin  (borrow_q),
    .diff (diff),
    .bout (bout)
  );

  // Next-state, operand capture, byte write-back and done pulse.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    x_d      = x_q;
    out_d    = out_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d      = x;
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = CALC;
        end
      end
      CALC: begin
        for (int j = 0; j <= NBYTES; j++) begin
          if (idx_q == IDX_W'(j)) out_d[8*j +: 8] = diff;
        end
        borrow_d = bout;
        if (idx_q == IDX_W'(NBYTES)) begin
          // The final borrow is dropped: the product already fits in OW signed bits.
          idx_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset; an abort clears everything including out.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      x_q      <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      x_q      <= x_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = done_q;
  assign out  = out_q;

endmodule
